// File: rtl/debouncer_multi.sv
// debouncer_multi: per-channel synchroniser plus N-sample debounce with registered rise/fall pulses.
// A shared sample_en strobe lets one prescaler stretch the debounce window of every channel.
module debouncer_multi #(
    parameter int              CH          = 4,
    parameter int              N           = 3,
    parameter int              SYNC_STAGES = 2,
    parameter logic [CH-1:0]   RST_VAL     = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] noisy_in,
    input  logic          sample_en,
    output logic [CH-1:0] debounced,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall
);
    localparam int CW = $clog2(N + 1);

    logic [SYNC_STAGES-1:0][CH-1:0] sync_q;
    logic [CH-1:0][CW-1:0]          cnt_q, cnt_d;
    logic [CH-1:0]                  deb_q, deb_d, rise_q, rise_d, fall_q, fall_d;
    logic [CH-1:0]                  s;

    assign s = sync_q[SYNC_STAGES-1];

    // A level matching the output always clears the count, even without a strobe.
    always_comb begin
        deb_d  = deb_q;
        cnt_d  = cnt_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < CH; i++) begin
            if (s[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (sample_en) begin
                if (cnt_q[i] == CW'(N - 1)) begin
                    deb_d[i]  = s[i];
                    cnt_d[i]  = '0;
                    rise_d[i] = s[i];
                    fall_d[i] = ~s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            cnt_q  <= '0;
            deb_q  <= RST_VAL;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], noisy_in};
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign debounced = deb_q;
    assign rise      = rise_q;
    assign fall      = fall_q;
endmodule
